// File: rtl/keypad_scan_ctrl.sv
// Scan controller for a 4x3 active-low matrix keypad: round-robin column drive,
// press/release debounce, one code per press, and a FWFT key-code FIFO for the host.
module keypad_scan_ctrl #(
    parameter int SCAN_DWELL = 4,
    parameter int DEBOUNCE   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] r,
    output logic [2:0] c,
    output logic [3:0] key_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow,
    output logic       key_error
);

    localparam int DW_W  = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_DWELL - 1);
    localparam logic [DW_W-1:0]  DW_ONE     = DW_W'(1);
    localparam logic [DB_W-1:0]  DB_TARGET  = DB_W'(DEBOUNCE);
    localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD
    } state_t;

    state_t            state_q;
    logic [2:0]        c_q;
    logic [DW_W-1:0]   dwell_q;
    logic [3:0]        pat_q;
    logic [DB_W-1:0]   stab_q;
    logic [DB_W-1:0]   rel_q;
    logic              push_q;
    logic [3:0]        push_code_q;
    logic              key_error_q;
    logic              key_held_q;

    logic [3:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;

    logic              idle_rows;
    logic              single_key;
    logic [2:0]        c_next;
    logic [DB_W-1:0]   stab_inc;
    logic              accept;
    logic [3:0]        code;
    logic              pop;
    logic              full;
    logic              do_push;

    assign idle_rows  = (r == 4'b1111);
    assign single_key = $onehot(~r);
    assign c_next     = {c_q[1:0], c_q[2]};

    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    always_comb begin
        stab_inc = (r == pat_q) ? stab_q + DB_ONE : DB_ONE;
        accept   = 1'b0;
        if (!idle_rows) begin
            if (state_q == ST_SCAN) begin
                accept = (dwell_q == DWELL_LAST) && (DEBOUNCE == 1);
            end else if (state_q == ST_DEBOUNCE) begin
                accept = (stab_inc >= DB_TARGET);
            end
        end
    end

    // Code table indexed by the driven column and the single low row.
    always_comb begin
        code = 4'd0;
        case ({c_q, r})
            7'b110_0111: code = 4'd3;
            7'b110_1011: code = 4'd6;
            7'b110_1101: code = 4'd9;
            7'b110_1110: code = 4'd11;
            7'b101_0111: code = 4'd2;
            7'b101_1011: code = 4'd5;
            7'b101_1101: code = 4'd8;
            7'b101_1110: code = 4'd0;
            7'b011_0111: code = 4'd1;
            7'b011_1011: code = 4'd4;
            7'b011_1101: code = 4'd7;
            7'b011_1110: code = 4'd10;
            default:     code = 4'd0;
        endcase
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            c_q         <= 3'b110;
            dwell_q     <= '0;
            pat_q       <= 4'b1111;
            stab_q      <= '0;
            rel_q       <= '0;
            push_q      <= 1'b0;
            push_code_q <= '0;
            key_error_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            key_error_q <= 1'b0;
            if (accept) begin
                state_q    <= ST_HELD;
                key_held_q <= 1'b1;
                rel_q      <= '0;
                dwell_q    <= '0;
                if (single_key) begin
                    push_q      <= 1'b1;
                    push_code_q <= code;
                end else begin
                    key_error_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_SCAN: begin
                        if (dwell_q == DWELL_LAST) begin
                            dwell_q <= '0;
                            if (idle_rows) begin
                                c_q <= c_next;
                            end else begin
                                pat_q   <= r;
                                stab_q  <= DB_ONE;
                                state_q <= ST_DEBOUNCE;
                            end
                        end else begin
                            dwell_q <= dwell_q + DW_ONE;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (idle_rows) begin
                            state_q <= ST_SCAN;
                            c_q     <= c_next;
                            dwell_q <= '0;
                        end else begin
                            pat_q  <= r;
                            stab_q <= stab_inc;
                        end
                    end
                    ST_HELD: begin
                        if (!idle_rows) begin
                            rel_q <= '0;
                        end else if (rel_q + DB_ONE == DB_TARGET) begin
                            state_q    <= ST_SCAN;
                            c_q        <= c_next;
                            dwell_q    <= '0;
                            rel_q      <= '0;
                            key_held_q <= 1'b0;
                        end else begin
                            rel_q <= rel_q + DB_ONE;
                        end
                    end
                    default: state_q <= ST_SCAN;
                endcase
            end
        end
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign pop     = key_valid && key_ready;
    assign full    = (count_q == FIFO_FULL);
    assign do_push = push_q && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_q && full && !pop;
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_code_q;
    end

    assign c         = c_q;
    assign key_valid = (count_q != '0);
    assign key_data  = key_valid ? mem_q[rd_ptr_q] : 4'd0;
    assign key_held  = key_held_q;
    assign overflow  = overflow_q;
    assign key_error = key_error_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical keypad drives r from c, and a behavioural
// model (queue FIFO, arithmetic key codes) is compared against the DUT every cycle.
module tb_keypad_scan_ctrl;

    localparam int SCAN_DWELL = 4;
    localparam int DEBOUNCE   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int MS = 0, MD = 1, MH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_ready;
    logic [3:0]  r;
    logic [2:0]  c;
    logic [3:0]  key_data;
    logic        key_valid;
    logic        key_held;
    logic        overflow;
    logic        key_error;
    logic [11:0] pressed;

    int total = 0;
    int bad   = 0;
    bit check_en  = 1'b0;
    bit rnd_ready = 1'b0;
    int pop_log[$];
    int ovf_seen = 0;
    int err_seen = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .SCAN_DWELL (SCAN_DWELL),
        .DEBOUNCE   (DEBOUNCE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .r         (r),
        .c         (c),
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow),
        .key_error (key_error)
    );

    // Keypad geometry: rowpos 0 = top row (1 2 3), colpos 0 = left column (1 4 7 *).
    function automatic int key_rowpos(int j);
        if (j >= 1 && j <= 9) return (j - 1) / 3;
        return 3;
    endfunction

    function automatic int key_colpos(int j);
        if (j >= 1 && j <= 9) return (j - 1) % 3;
        if (j == 0) return 1;
        if (j == 10) return 0;
        return 2;
    endfunction

    function automatic logic [1:0] key_cbit(int j);
        return 2'(2 - key_colpos(j));
    endfunction

    function automatic logic [1:0] key_rbit(int j);
        return 2'(3 - key_rowpos(j));
    endfunction

    // A row line is pulled low when a pressed key sits on the currently driven column.
    always_comb begin
        r = 4'b1111;
        for (int j = 0; j < 12; j++) begin
            if (pressed[4'(j)] && c[key_cbit(j)] === 1'b0) r[key_rbit(j)] = 1'b0;
        end
    end

    // Code from driven column index k (0: c=110) and a single-low row pattern.
    function automatic int key_code(int k, logic [3:0] rr);
        int rowbit;
        int rowpos;
        int colpos;
        rowbit = 0;
        for (int b = 0; b < 4; b++) if (!rr[2'(b)]) rowbit = b;
        rowpos = 3 - rowbit;
        colpos = 2 - k;
        if (rowpos < 3) return rowpos * 3 + colpos + 1;
        case (colpos)
            0:       return 10;
            1:       return 0;
            default: return 11;
        endcase
    endfunction

    function automatic logic [2:0] col_drive(int k);
        case (k)
            0:       return 3'b110;
            1:       return 3'b101;
            default: return 3'b011;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model state.
    int         m_col  = 0;
    int         m_mode = MS;
    int         m_timer = 0;
    int         m_stab = 0;
    int         m_rel  = 0;
    int         m_pend = -1;
    int         m_pend_next = -1;
    logic [3:0] m_pat = 4'b1111;
    int         m_q[$];
    bit         m_ovf = 1'b0;
    bit         m_err = 1'b0;
    bit         m_pop;
    bit         m_full;

    task automatic model_accept(input logic [3:0] pat);
        m_mode = MH;
        m_rel  = 0;
        if ($countones(~pat) == 1) m_pend_next = key_code(m_col, pat);
        else m_err = 1'b1;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_col = 0; m_mode = MS; m_timer = 0; m_stab = 0; m_rel = 0;
            m_pend = -1; m_pat = 4'b1111; m_q.delete(); m_ovf = 1'b0; m_err = 1'b0;
        end else begin
            m_pop  = (m_q.size() > 0) && (key_ready === 1'b1);
            m_full = (m_q.size() == FIFO_DEPTH);
            m_ovf  = 1'b0;
            if (m_pop) void'(m_q.pop_front());
            if (m_pend >= 0) begin
                if (!m_full || m_pop) m_q.push_back(m_pend);
                else m_ovf = 1'b1;
            end
            m_pend_next = -1;
            m_err = 1'b0;
            case (m_mode)
                MS: begin
                    if (m_timer == SCAN_DWELL - 1) begin
                        m_timer = 0;
                        if (r == 4'b1111) m_col = (m_col + 1) % 3;
                        else begin
                            m_pat  = r;
                            m_stab = 1;
                            if (m_stab >= DEBOUNCE) model_accept(r);
                            else m_mode = MD;
                        end
                    end else begin
                        m_timer++;
                    end
                end
                MD: begin
                    if (r == 4'b1111) begin
                        m_mode = MS; m_col = (m_col + 1) % 3; m_timer = 0;
                    end else begin
                        m_stab = (r == m_pat) ? m_stab + 1 : 1;
                        m_pat  = r;
                        if (m_stab >= DEBOUNCE) model_accept(r);
                    end
                end
                default: begin
                    if (r != 4'b1111) m_rel = 0;
                    else begin
                        m_rel++;
                        if (m_rel >= DEBOUNCE) begin
                            m_mode = MS; m_col = (m_col + 1) % 3; m_timer = 0;
                        end
                    end
                end
            endcase
            m_pend = m_pend_next;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("c", 32'(c), 32'(col_drive(m_col)));
            check("key_valid", 32'(key_valid), 32'(m_q.size() > 0));
            check("key_data", 32'(key_data), (m_q.size() > 0) ? m_q[0] : 0);
            check("key_held", 32'(key_held), 32'(m_mode == MH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("key_error", 32'(key_error), 32'(m_err));
        end
    end

    always @(posedge clk) begin
        if (reset === 1'b0 && key_valid === 1'b1 && key_ready === 1'b1) pop_log.push_back(int'(key_data));
    end

    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_seen++;
        if (key_error === 1'b1) err_seen++;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rnd_ready) key_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int pop_at(int i);
        if (i < pop_log.size()) return pop_log[i];
        return -1;
    endfunction

    initial begin
        int         seq[5];
        int         found;
        logic [3:0] j;
        logic [3:0] j2;
        int         sel;

        reset = 1'b1;
        key_ready = 1'b0;
        pressed = '0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        check("rst_c", 32'(c), 32'(3'b110));
        check("rst_valid", 32'(key_valid), 0);
        check("rst_data", 32'(key_data), 0);
        check("rst_held", 32'(key_held), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_err", 32'(key_error), 0);
        reset = 1'b0;

        // Idle scan: column advances every SCAN_DWELL cycles.
        cycles(4);
        check("s1_c_101", 32'(c), 32'(3'b101));
        cycles(4);
        check("s1_c_011", 32'(c), 32'(3'b011));
        cycles(4);
        check("s1_c_110", 32'(c), 32'(3'b110));
        cycles(18);
        check("s1_valid", 32'(key_valid), 0);

        // Single press of '5' with the host always ready.
        key_ready = 1'b1;
        pop_log.delete();
        pressed[5] = 1'b1;
        cycles(40);
        check("s2_c_hold", 32'(c), 32'(3'b101));
        check("s2_held", 32'(key_held), 1);
        cycles(20);
        pressed[5] = 1'b0;
        cycles(7);
        check("s2_c_before_rel", 32'(c), 32'(3'b101));
        cycles(1);
        check("s2_c_after_rel", 32'(c), 32'(3'b011));
        check("s2_pops", pop_log.size(), 1);
        check("s2_code", pop_at(0), 5);

        // Bouncing '#': no push during bounce, one push once stable.
        pop_log.delete();
        for (int i = 0; i < 5; i++) begin
            pressed[11] = 1'b1;
            cycles(3);
            pressed[11] = 1'b0;
            cycles(3);
        end
        check("s3_bounce_pops", pop_log.size(), 0);
        pressed[11] = 1'b1;
        cycles(45);
        pressed[11] = 1'b0;
        cycles(20);
        check("s3_pops", pop_log.size(), 1);
        check("s3_code", pop_at(0), 11);

        // FIFO fill with host stalled: fifth code dropped.
        key_ready = 1'b0;
        pop_log.delete();
        ovf_seen = 0;
        seq = '{1, 2, 3, 4, 7};
        foreach (seq[i]) begin
            pressed[4'(seq[i])] = 1'b1;
            cycles(40);
            pressed[4'(seq[i])] = 1'b0;
            cycles(20);
        end
        check("s4_ovf_pulses", ovf_seen, 1);
        check("s4_valid_full", 32'(key_valid), 1);
        check("s4_head", 32'(key_data), 1);
        key_ready = 1'b1;
        cycles(8);
        check("s4_pops", pop_log.size(), 4);
        check("s4_pop0", pop_at(0), 1);
        check("s4_pop1", pop_at(1), 2);
        check("s4_pop2", pop_at(2), 3);
        check("s4_pop3", pop_at(3), 4);
        check("s4_valid_empty", 32'(key_valid), 0);

        // Two keys in one column: error pulse, no push.
        pop_log.delete();
        err_seen = 0;
        pressed[1] = 1'b1;
        pressed[4] = 1'b1;
        cycles(40);
        check("s5_held", 32'(key_held), 1);
        check("s5_err_pulses", err_seen, 1);
        pressed = '0;
        cycles(7);
        check("s5_held_before_rel", 32'(key_held), 1);
        cycles(1);
        check("s5_held_after_rel", 32'(key_held), 0);
        check("s5_pops", pop_log.size(), 0);

        // Reset during debounce with one code queued.
        key_ready = 1'b0;
        pressed[9] = 1'b1;
        cycles(40);
        pressed[9] = 1'b0;
        cycles(20);
        check("s6_queued_valid", 32'(key_valid), 1);
        check("s6_queued_data", 32'(key_data), 9);
        pressed[6] = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(negedge clk);
            if (m_mode == MD) found = 1;
        end
        check("s6_reach_debounce", found, 1);
        reset = 1'b1;
        pressed[6] = 1'b0;
        @(negedge clk);
        check("s6_rst_c", 32'(c), 32'(3'b110));
        check("s6_rst_valid", 32'(key_valid), 0);
        check("s6_rst_data", 32'(key_data), 0);
        check("s6_rst_held", 32'(key_held), 0);
        reset = 1'b0;
        cycles(30);
        check("s6_no_push", 32'(key_valid), 0);

        // Randomized presses, chords, bounces, host stalls and occasional resets.
        rnd_ready = 1'b1;
        for (int it = 0; it < 150; it++) begin
            sel = int'($urandom_range(0, 19));
            j   = 4'($urandom_range(0, 11));
            j2  = 4'($urandom_range(0, 11));
            if (sel == 0) begin
                reset = 1'b1;
                cycles(int'($urandom_range(1, 2)));
                reset = 1'b0;
            end else if (sel < 4) begin
                pressed[j]  = 1'b1;
                pressed[j2] = 1'b1;
                cycles(int'($urandom_range(5, 40)));
                pressed = '0;
            end else if (sel < 7) begin
                for (int b = 0; b < int'($urandom_range(2, 6)); b++) begin
                    pressed[j] = 1'b1;
                    cycles(int'($urandom_range(1, 4)));
                    pressed[j] = 1'b0;
                    cycles(int'($urandom_range(1, 4)));
                end
                pressed[j] = 1'b1;
                cycles(int'($urandom_range(0, 40)));
                pressed[j] = 1'b0;
            end else begin
                pressed[j] = 1'b1;
                cycles(int'($urandom_range(1, 40)));
                pressed[j] = 1'b0;
            end
            cycles(int'($urandom_range(0, 25)));
        end
        rnd_ready = 1'b0;
        key_ready = 1'b1;
        pressed = '0;
        cycles(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
